// File: rtl/alorium_lfsr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alorium_lfsr_pkg : shared constants, FSM encoding and Galois step function
// Revision: 1.0
// ---------------------------------------------------------------------------
package alorium_lfsr_pkg;

  // Maximal-length Galois feedback masks for common widths
  localparam logic [7:0]  POLY_W8  = 8'hB8;
  localparam logic [15:0] POLY_W16 = 16'hB400;
  localparam logic [31:0] POLY_W32 = 32'hA3000000;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } lfsr_state_t;

  // Operates on a zero-extended 32-bit view so callers of any width can share it
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur,
                                            input logic [31:0] poly);
    lfsr_next = (cur >> 1) ^ (cur[0] ? poly : 32'h0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alorium_lfsr_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alorium_lfsr_gen : Galois LFSR with seed load, single-step and burst modes
// Revision: 1.0
// ---------------------------------------------------------------------------
module alorium_lfsr_gen
  import alorium_lfsr_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] POLY       = 'hB400,
  parameter logic [WIDTH-1:0] RESET_SEED = 'h0001
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             new_seed,
  input  logic [WIDTH-1:0] seed,
  input  logic             enable,
  input  logic             burst_start,
  input  logic [7:0]       burst_len,
  output logic [WIDTH-1:0] lfsr_data,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             seed_err
);

  lfsr_state_t      state;
  logic [WIDTH-1:0] anchor;
  logic [7:0]       remaining;
  logic [WIDTH-1:0] next_data;
  logic             next_hits_anchor;

  assign next_data        = WIDTH'(lfsr_next(32'(lfsr_data), 32'(POLY)));
  assign next_hits_anchor = (next_data == anchor);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      lfsr_data <= RESET_SEED;
      anchor    <= RESET_SEED;
      remaining <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
      seed_err  <= 1'b0;
    end else begin
      done     <= 1'b0;
      wrap     <= 1'b0;
      seed_err <= 1'b0;

      if (new_seed) begin
        // A zero seed would lock the register up, so the reset seed stands in
        if (seed == '0) begin
          lfsr_data <= RESET_SEED;
          anchor    <= RESET_SEED;
          seed_err  <= 1'b1;
        end else begin
          lfsr_data <= seed;
          anchor    <= seed;
        end
        state     <= ST_IDLE;
        busy      <= 1'b0;
        remaining <= 8'd0;
      end else begin
        case (state)
          ST_BURST: begin
            lfsr_data <= next_data;
            wrap      <= next_hits_anchor;
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: begin
            if (burst_start) begin
              remaining <= burst_len;
              if (burst_len == 8'd0) begin
                done <= 1'b1;
              end else begin
                state <= ST_BURST;
                busy  <= 1'b1;
              end
            end else if (enable) begin
              lfsr_data <= next_data;
              wrap      <= next_hits_anchor;
            end
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alorium_lfsr_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alorium_lfsr_gen : directed self-checking bench for alorium_lfsr_gen
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_alorium_lfsr_gen;

  logic        clk;
  logic        reset_n;
  logic        new_seed;
  logic [15:0] seed;
  logic        enable;
  logic        burst_start;
  logic [7:0]  burst_len;
  logic [15:0] lfsr_data;
  logic        busy;
  logic        done;
  logic        wrap;
  logic        seed_err;

  int pass_cnt;
  int total_cnt;

  alorium_lfsr_gen #(
    .WIDTH      (16),
    .POLY       (16'hB400),
    .RESET_SEED (16'h0001)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .new_seed    (new_seed),
    .seed        (seed),
    .enable      (enable),
    .burst_start (burst_start),
    .burst_len   (burst_len),
    .lfsr_data   (lfsr_data),
    .busy        (busy),
    .done        (done),
    .wrap        (wrap),
    .seed_err    (seed_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_seed(input logic [15:0] value);
    @(negedge clk);
    new_seed = 1'b1;
    seed     = value;
    @(negedge clk);
    new_seed = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    total_cnt++;
    if (lfsr_data !== 16'h0001)
      $display("FAIL reset_data: got %h expected %h", lfsr_data, 16'h0001);
    else pass_cnt++;
    total_cnt++;
    if ({busy, done, wrap, seed_err} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected %b", {busy, done, wrap, seed_err}, 4'b0000);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    total_cnt++;
    if (lfsr_data !== 16'hB400)
      $display("FAIL reset_first_step: got %h expected %h", lfsr_data, 16'hB400);
    else pass_cnt++;
  endtask

  task automatic test_seed_step();
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'hE270;
    exp_seq[1] = 16'h7138;
    exp_seq[2] = 16'h389C;
    load_seed(16'hACE1);
    total_cnt++;
    if (lfsr_data !== 16'hACE1 || seed_err !== 1'b0)
      $display("FAIL seed_load: got data %h err %b expected %h err 0", lfsr_data, seed_err, 16'hACE1);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      total_cnt++;
      if (lfsr_data !== exp_seq[i])
        $display("FAIL step_%0d: got %h expected %h", i, lfsr_data, exp_seq[i]);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (lfsr_data !== exp_seq[i])
        $display("FAIL hold_%0d: got %h expected %h", i, lfsr_data, exp_seq[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_zero_seed();
    load_seed(16'h5555);
    @(negedge clk);
    new_seed = 1'b1;
    seed     = 16'h0000;
    @(negedge clk);
    new_seed = 1'b0;
    total_cnt++;
    if (lfsr_data !== 16'h0001 || seed_err !== 1'b1)
      $display("FAIL zero_seed: got data %h err %b expected 0001 err 1", lfsr_data, seed_err);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (seed_err !== 1'b0)
      $display("FAIL zero_seed_pulse: got err %b expected 0", seed_err);
    else pass_cnt++;
  endtask

  task automatic test_burst();
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'hACE1;
    exp_seq[1] = 16'hE270;
    exp_seq[2] = 16'h7138;
    exp_seq[3] = 16'h389C;
    load_seed(16'hACE1);
    burst_len   = 8'd3;
    burst_start = 1'b1;
    enable      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      burst_start = 1'b0;
      total_cnt++;
      if (lfsr_data !== exp_seq[i] || busy !== (i < 3) || done !== (i == 3))
        $display("FAIL burst_cycle_%0d: got data %h busy %b done %b expected %h busy %b done %b",
                 i, lfsr_data, busy, done, exp_seq[i], (i < 3), (i == 3));
      else pass_cnt++;
    end
    // Back-to-back zero-length burst accepted in the done cycle
    enable      = 1'b0;
    burst_len   = 8'd0;
    burst_start = 1'b1;
    @(negedge clk);
    burst_start = 1'b0;
    total_cnt++;
    if (lfsr_data !== 16'h389C || busy !== 1'b0 || done !== 1'b1)
      $display("FAIL burst_zero: got data %h busy %b done %b expected 389c busy 0 done 1",
               lfsr_data, busy, done);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (lfsr_data !== 16'h389C || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL burst_zero_after: got data %h busy %b done %b expected 389c busy 0 done 0",
               lfsr_data, busy, done);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int done_seen;
    load_seed(16'hACE1);
    burst_len   = 8'd100;
    burst_start = 1'b1;
    @(negedge clk);
    burst_start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1)
      $display("FAIL abort_busy_start: got %b expected 1", busy);
    else pass_cnt++;
    repeat (5) @(negedge clk);
    new_seed = 1'b1;
    seed     = 16'h1234;
    @(negedge clk);
    new_seed = 1'b0;
    total_cnt++;
    if (lfsr_data !== 16'h1234 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abort: got data %h busy %b done %b expected 1234 busy 0 done 0",
               lfsr_data, busy, done);
    else pass_cnt++;
    done_seen = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    total_cnt++;
    if (done_seen !== 0 || lfsr_data !== 16'h1234)
      $display("FAIL abort_quiet: got done/busy cycles %0d data %h expected 0 and 1234",
               done_seen, lfsr_data);
    else pass_cnt++;
  endtask

  task automatic test_period();
    int          wraps;
    int          wrap_step;
    logic [15:0] wrap_data;
    wraps     = 0;
    wrap_step = -1;
    wrap_data = 16'h0;
    load_seed(16'hACE1);
    enable = 1'b1;
    for (int i = 1; i <= 65535; i++) begin
      @(negedge clk);
      if (wrap === 1'b1) begin
        wraps++;
        wrap_step = i;
        wrap_data = lfsr_data;
      end
    end
    enable = 1'b0;
    total_cnt++;
    if (wraps !== 1)
      $display("FAIL period_wrap_count: got %0d expected 1", wraps);
    else pass_cnt++;
    total_cnt++;
    if (wrap_step !== 65535 || wrap_data !== 16'hACE1)
      $display("FAIL period_wrap_step: got step %0d data %h expected 65535 data ace1",
               wrap_step, wrap_data);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (wrap !== 1'b0 || lfsr_data !== 16'hACE1)
      $display("FAIL period_after: got wrap %b data %h expected 0 ace1", wrap, lfsr_data);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt    = 0;
    total_cnt   = 0;
    reset_n     = 1'b0;
    new_seed    = 1'b0;
    seed        = 16'h0;
    enable      = 1'b0;
    burst_start = 1'b0;
    burst_len   = 8'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    test_reset();
    test_seed_step();
    test_zero_seed();
    test_burst();
    test_abort();
    test_period();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
